// File: rtl/spi_pkg.sv
// Shared definitions for the SPI byte transmitter: state encoding, widths
// and the default sclk half-period length.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } spi_state_e;

  localparam int BYTE_WIDTH  = 8;
  localparam int NUM_PULSES  = 10;
  localparam int DEF_CLK_DIV = 4;

  // Counter width able to hold div-1, never narrower than one bit.
  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer: while enabled, pulses tick on every CLK_DIV-th cycle
// and restarts from zero, so each phase begins with a cleared count.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = cnt_width(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Half-period counter, held at zero while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_master_tx.sv
// SPI byte transmitter: wake-up pulse, eight MSB-first data pulses and a
// completion pulse framed by an active-low chip select.
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BYTE_WIDTH-1:0] din,
  output logic                  busy,
  output logic                  done,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  cs
);

  localparam logic [3:0] LAST_PULSE = 4'(NUM_PULSES - 1);
  localparam logic [3:0] LAST_DATA  = 4'(BYTE_WIDTH);

  spi_state_e            state, state_nxt;
  logic [3:0]            pulse, pulse_nxt;
  logic                  phase_low, phase_low_nxt;
  logic [BYTE_WIDTH-1:0] shreg, shreg_nxt;
  logic                  tick;
  logic                  cs_nxt, sclk_nxt, mosi_nxt, busy_nxt, done_nxt;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk  (clk),
    .rst  (rst),
    .en   (state != IDLE),
    .tick (tick)
  );

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pulse     <= 4'd0;
      phase_low <= 1'b0;
      shreg     <= '0;
      cs        <= 1'b1;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      pulse     <= pulse_nxt;
      phase_low <= phase_low_nxt;
      shreg     <= shreg_nxt;
      cs        <= cs_nxt;
      sclk      <= sclk_nxt;
      mosi      <= mosi_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  // Next-state logic; the shift register advances as pulses 2..8 begin.
  always_comb begin
    state_nxt     = state;
    pulse_nxt     = pulse;
    phase_low_nxt = phase_low;
    shreg_nxt     = shreg;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt     = SETUP;
          shreg_nxt     = din;
          pulse_nxt     = 4'd0;
          phase_low_nxt = 1'b0;
        end else begin
          state_nxt = IDLE;
        end
      end
      SETUP: begin
        if (tick) begin
          state_nxt = SHIFT;
        end else begin
          state_nxt = SETUP;
        end
      end
      SHIFT: begin
        if (tick && !phase_low) begin
          phase_low_nxt = 1'b1;
        end else if (tick && (pulse == LAST_PULSE)) begin
          state_nxt     = HOLD;
          phase_low_nxt = 1'b0;
        end else if (tick) begin
          pulse_nxt     = pulse + 4'd1;
          phase_low_nxt = 1'b0;
          if ((pulse >= 4'd1) && (pulse < LAST_DATA)) begin
            shreg_nxt = {shreg[BYTE_WIDTH-2:0], 1'b0};
          end else begin
            shreg_nxt = shreg;
          end
        end else begin
          state_nxt = SHIFT;
        end
      end
      HOLD: begin
        if (tick) begin
          state_nxt = IDLE;
          pulse_nxt = 4'd0;
        end else begin
          state_nxt = HOLD;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state.
  always_comb begin
    cs_nxt   = (state_nxt == IDLE);
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state == HOLD) && tick;
    sclk_nxt = (state_nxt == SHIFT) && !phase_low_nxt;
    if ((state_nxt == SHIFT) && (pulse_nxt >= 4'd1) && (pulse_nxt <= LAST_DATA)) begin
      mosi_nxt = shreg_nxt[BYTE_WIDTH-1];
    end else begin
      mosi_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_master_tx.sv
// Self-checking bench for spi_master_tx at CLK_DIV=4 and CLK_DIV=1.
module tb_spi_master_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       start_v = 1'b0;
  logic [7:0] din_v = 8'h00;

  logic       start4, start1;
  logic       busy4, done4, sclk4, mosi4, cs4;
  logic       busy1, done1, sclk1, mosi1, cs1;
  logic [4:0] obs;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  assign start4 = !sel && start_v;
  assign start1 = sel && start_v;
  assign obs = sel ? {cs1, sclk1, mosi1, busy1, done1}
                   : {cs4, sclk4, mosi4, busy4, done4};

  spi_master_tx #(.CLK_DIV(4)) u_div4 (
    .clk(clk), .rst(rst), .start(start4), .din(din_v),
    .busy(busy4), .done(done4), .sclk(sclk4), .mosi(mosi4), .cs(cs4)
  );

  spi_master_tx #(.CLK_DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .start(start1), .din(din_v),
    .busy(busy1), .done(done1), .sclk(sclk1), .mosi(mosi1), .cs(cs1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {cs,sclk,mosi,busy,done} k cycles after start is accepted.
  function automatic logic [4:0] expect_vec(input logic [7:0] b, input int d, input int k);
    int   m, p;
    logic s, mo;
    if (k == 22 * d + 1) return 5'b10001;
    s  = 1'b0;
    mo = 1'b0;
    if (k > d && k <= 21 * d) begin
      m = k - d - 1;
      p = m / (2 * d);
      s = ((m % (2 * d)) < d);
      if (p >= 1 && p <= 8) mo = b[8 - p];
    end
    return {1'b0, s, mo, 1'b1, 1'b0};
  endfunction

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle", 32'(obs), 32'(5'b10000));
    end
  endtask

  // One transfer started at the current negedge; returns at the done-cycle negedge.
  task automatic xfer(input logic [7:0] b, input int d, input int abort_k, input bit inject);
    bit         q[$];
    logic       prev_sclk;
    logic [9:0] got;
    start_v   = 1'b1;
    din_v     = b;
    prev_sclk = 1'b0;
    for (int k = 1; k <= 22 * d + 1; k++) begin
      @(negedge clk);
      check("wave", 32'(obs), 32'(expect_vec(b, d, k)));
      if (prev_sclk && !obs[3]) q.push_back(obs[2]);
      prev_sclk = obs[3];
      if (k == 1) begin
        start_v = 1'b0;
        din_v   = 8'($urandom);
      end
      if (inject && k == 5 * d) begin
        start_v = 1'b1;
        din_v   = 8'hFF;
      end else if (inject && k == 5 * d + 1) begin
        start_v = 1'b0;
      end
      if (abort_k != 0 && k == abort_k) begin
        rst     = 1'b1;
        start_v = 1'b1;
        @(negedge clk);
        check("abort", 32'(obs), 32'(5'b10000));
        rst     = 1'b0;
        start_v = 1'b0;
        return;
      end
    end
    check("rx_bits", 32'(q.size()), 32'd10);
    got = '0;
    foreach (q[i]) got = {got[8:0], q[i]};
    check("rx_byte", 32'(got), 32'({1'b0, b, 1'b0}));
  endtask

  initial begin
    logic [7:0] r;
    repeat (3) @(negedge clk);
    check("rst_div4", 32'({cs4, sclk4, mosi4, busy4, done4}), 32'(5'b10000));
    check("rst_div1", 32'({cs1, sclk1, mosi1, busy1, done1}), 32'(5'b10000));
    rst = 1'b0;
    idle_check(2);

    xfer(8'hA5, 4, 0, 1'b0);
    idle_check(2);
    xfer(8'h3C, 4, 0, 1'b0);
    xfer(8'hC3, 4, 0, 1'b0);
    idle_check(2);
    xfer(8'h00, 4, 0, 1'b1);
    idle_check(6);
    xfer(8'h5A, 4, 7 * 4 + 1, 1'b0);
    idle_check(4);
    xfer(8'h81, 4, 0, 1'b0);
    idle_check(1);
    for (int i = 0; i < 6; i++) begin
      r = 8'($urandom);
      xfer(r, 4, 0, 1'b0);
      if ($urandom_range(0, 1) == 1) idle_check(int'($urandom_range(1, 3)));
    end
    idle_check(1);

    sel = 1'b1;
    idle_check(2);
    xfer(8'h00, 1, 0, 1'b0);
    idle_check(1);
    xfer(8'hFF, 1, 0, 1'b0);
    xfer(8'h96, 1, 0, 1'b1);
    idle_check(3);
    xfer(8'h42, 1, 6, 1'b0);
    idle_check(2);
    for (int i = 0; i < 4; i++) begin
      r = 8'($urandom);
      xfer(r, 1, 0, 1'b0);
      if ($urandom_range(0, 1) == 1) idle_check(int'($urandom_range(1, 3)));
    end
    idle_check(2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
